wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 32 +++
 rtl/wb_cp0.sv | 79 +++++++
 rtl/wb_stage.sv | 65 ++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage definitions: bus layout, CP0 addresses, exception vector.
// The optional CP0 timer is enabled by defining CP0_TIMER_EN.
package wb_stage_pkg;

    localparam int MS_TO_WS_BUS_WD = 115;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [31:0] EX_ENTRY = 32'hbfc0_0380;

    typedef struct packed {
        logic        mtc0_we;
        logic [4:0]  cp0_addr;
        logic        res_from_cp0;
        logic [31:0] rt_value;
        logic        ex;
        logic [4:0]  excode;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    function automatic logic [31:0] cause_word(logic ti, logic [4:0] code);
        return {1'b0, ti, 23'd0, code, 2'b00};
    endfunction

endpackage

// File: rtl/wb_cp0.sv
// CP0 register file: Status.EXL, Cause (TI, ExcCode), EPC.
// Count/Compare and the timer interrupt exist only when CP0_TIMER_EN is defined.
import wb_stage_pkg::*;

module wb_cp0 (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic        ex,
    input  logic [4:0]  excode,
    input  logic [31:0] ex_pc,
    output logic [31:0] rdata
);

    logic        exl;
    logic [4:0]  exccode;
    logic [31:0] epc;
    logic        ti;

    // EPC only captures the first exception; nested ones keep the original
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exl     <= 1'b0;
            exccode <= 5'd0;
            epc     <= 32'd0;
        end else if (ex) begin
            exl     <= 1'b1;
            exccode <= excode;
            if (!exl) epc <= ex_pc;
        end else if (we) begin
            if (addr == CP0_STATUS) exl <= wdata[1];
            if (addr == CP0_EPC)    epc <= wdata;
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= 32'd0;
            compare <= 32'd0;
            tick    <= 1'b0;
            ti      <= 1'b0;
        end else begin
            tick <= ~tick;
            if (we && addr == CP0_COUNT) count <= wdata;
            else if (tick)               count <= count + 32'd1;
            if (we && addr == CP0_COMPARE) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end
`else
    assign ti = 1'b0;
`endif

    always_comb begin
        rdata = 32'd0;
        case (addr)
            CP0_STATUS:  rdata = {30'd0, exl, 1'b0};
            CP0_CAUSE:   rdata = cause_word(ti, exccode);
            CP0_EPC:     rdata = epc;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   rdata = count;
            CP0_COMPARE: rdata = compare;
`endif
            default:     rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions to the register file and owns CP0.
// Build option CP0_TIMER_EN adds Count/Compare and the timer interrupt.
import wb_stage_pkg::*;

module wb_stage (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                       ws_allowin,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic                       ex_from_ws,
    output logic [31:0]                ex_target,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    logic        ws_valid;
    logic        ws_ready_go;
    ms_to_ws_t   ws_bus;
    logic [31:0] cp0_rdata;
    logic        cp0_we;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           ws_valid <= 1'b0;
        else if (ws_allowin) ws_valid <= ms_to_ws_valid;
    end

    always_ff @(posedge clk) begin
        if (ws_allowin && ms_to_ws_valid) ws_bus <= ms_to_ws_bus;
    end

    assign ex_from_ws = ws_valid && ws_bus.ex;
    assign ex_target  = EX_ENTRY;
    assign cp0_we     = ws_valid && ws_bus.mtc0_we && !ws_bus.ex;

    wb_cp0 u_cp0 (
        .clk    (clk),
        .reset  (reset),
        .we     (cp0_we),
        .addr   (ws_bus.cp0_addr),
        .wdata  (ws_bus.rt_value),
        .ex     (ex_from_ws),
        .excode (ws_bus.excode),
        .ex_pc  (ws_bus.pc),
        .rdata  (cp0_rdata)
    );

    assign rf_we    = ws_valid && ws_bus.gr_we && !ws_bus.ex;
    assign rf_waddr = ws_bus.dest;
    assign rf_wdata = ws_bus.res_from_cp0 ? cp0_rdata : ws_bus.final_result;

    assign debug_wb_pc       = ws_bus.pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
